// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential divide controller: FSM encoding,
// HI/LO result split and the Execute-stage divide opcodes.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Divider result layout is {remainder, quotient} = {HI, LO}
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/muldiv_seq.sv
// Sequences a multi-cycle divider from the Execute stage: latches operands,
// stalls the front of the pipe, and writes HI/LO once when the result arrives.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_e,
    input  logic        signed_e,
    input  logic [31:0] srca_e,
    input  logic [31:0] srcb_e,
    input  logic        flush_e,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        stall_div,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        div_timeout,
    output logic [1:0]  state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, capture, expire;

    // Valid/ready: the divider consumes div_op*/div_signed while div_start is
    // high; div_ready is a one-shot result valid, taken in BUSY unless flushed.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_annul = 1'b0;
        stall_div = 1'b0;
        hilo_we   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (div_req_e && !flush_e) begin
                    accept    = 1'b1;
                    stall_div = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_div = 1'b1;
                if (flush_e) begin
                    div_annul = 1'b1;
                    state_d   = ST_IDLE;
                end else if (div_ready) begin
                    div_start = 1'b1;
                    capture   = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    div_annul = 1'b1;
                    expire    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    div_start = 1'b1;
                end
            end
            ST_DONE: begin
                // Stall released here so the DIV leaves Execute; the request is ignored
                hilo_we = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            div_start = 1'b0;
            div_annul = 1'b0;
            stall_div = 1'b0;
            hilo_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_op1     <= '0;
            div_op2     <= '0;
            div_signed  <= 1'b0;
            hi_wdata    <= '0;
            lo_wdata    <= '0;
            div_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                div_op1    <= srca_e;
                div_op2    <= srcb_e;
                div_signed <= signed_e;
                cnt_q      <= '0;
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                hi_wdata <= div_result[HI_MSB:HI_LSB];
                lo_wdata <= div_result[LO_MSB:LO_LSB];
            end
            if (expire) begin
                div_timeout <= 1'b1;
            end
        end
    end

    assign state_dbg = state_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum number of BUSY cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 6, meaning the busy-counter width; CNT_W SHALL hold TIMEOUT.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port div_req_e, input, 1: a DIV/DIVU instruction is in the Execute stage.
REQ-006 SHALL have port signed_e, input, 1: 1 = DIV, 0 = DIVU.
REQ-007 SHALL have port srca_e, input, 32: the forwarded dividend.
REQ-008 SHALL have port srcb_e, input, 32: the forwarded divisor.
REQ-009 SHALL have port flush_e, input, 1: the Execute instruction is squashed.
REQ-010 SHALL have port div_ready, input, 1: the divider result is valid.
REQ-011 SHALL have port div_result, input, 64: {remainder, quotient} from the divider.
REQ-012 SHALL have port div_start, output, 1, driven to the divider start_i.
REQ-013 SHALL have port div_annul, output, 1, driven to the divider annul_i.
REQ-014 SHALL have ports div_signed, output, 1, and div_op1 and div_op2, output, 32 each: the latched operands.
REQ-015 SHALL have port stall_div, output, 1: holds PC, the F/D register and the D/E register.
REQ-016 SHALL have port hilo_we, output, 1: the HI/LO write strobe.
REQ-017 SHALL have ports hi_wdata and lo_wdata, output, 32 each.
REQ-018 SHALL have port div_timeout, output, 1: a sticky error flag.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-020 IDLE, on div_req_e=1 and flush_e=0: SHALL latch srca_e, srcb_e and signed_e, clear the counter, assert stall_div combinationally the same cycle, and move to BUSY.
REQ-021 IDLE, on div_req_e=1 and flush_e=1: SHALL take no action and stay in IDLE.
REQ-022 BUSY: SHALL hold div_start=1 and stall_div=1, keep div_op1, div_op2 and div_signed constant, and increment the counter each cycle.
REQ-023 BUSY with div_ready=1: SHALL register div_result[63:32] into hi_wdata and div_result[31:0] into lo_wdata, then move to DONE.
REQ-024 BUSY with flush_e=1: SHALL pulse div_annul=1 for that cycle, drop div_start, write nothing, and move to IDLE; flush_e takes priority over div_ready in the same cycle.
REQ-025 BUSY with counter = TIMEOUT-1 and no div_ready: SHALL pulse div_annul, set div_timeout, write nothing, and move to IDLE.
REQ-026 DONE: SHALL drive hilo_we=1 for exactly one cycle with stall_div=0, so the DIV leaves Execute, and then move to IDLE.
REQ-027 DONE: SHALL ignore div_req_e, so the same instruction does not restart the divider.
REQ-028 Latency from IDLE accept to hilo_we SHALL be N+2 cycles, where N is the number of BUSY cycles before div_ready.
REQ-029 div_start SHALL be 0 in IDLE and DONE.
REQ-030 div_annul SHALL be 0 except for the single-cycle pulses in REQ-024 and REQ-025.
REQ-031 hilo_we SHALL never assert in IDLE or BUSY.
REQ-032 Divide-by-zero SHALL be passed to the divider unchanged; the result is whatever the divider returns, with no special casing here.
REQ-033 Back-to-back DIVs: the second DIV SHALL be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-034 On rst=1 at a clock edge: state SHALL be IDLE, the counter 0, and div_op1, div_op2, hi_wdata and lo_wdata 0.
REQ-035 On rst=1 at a clock edge: div_signed, div_timeout and hilo_we SHALL be 0.
REQ-036 While rst=1: stall_div, div_start and div_annul SHALL be 0.
REQ-037 Reset mid-BUSY SHALL abandon the operation without a HI/LO write and without a div_annul pulse; the divider is reset by the same rst.

Structure
REQ-038 The state encoding and the HI/LO result-split constants SHALL live in the shared defines header alongside the EXE_DIV_OP and EXE_DIVU_OP definitions.
REQ-039 The block SHALL be a single module with no sub-modules.
REQ-040 The datapath SHALL instantiate muldiv_seq between its Execute stage and the divider, and OR stall_div into the hazard-unit stalls.

Verification
REQ-041 Signed divide: DIV srca=-7 (0xFFFFFFF9), srcb=2, divider returns ready after 34 cycles -> hilo_we on cycle 36, HI=0xFFFFFFFF, LO=0xFFFFFFFD, stall_div high for cycles 0..35.
REQ-042 Unsigned divide: DIVU srca=100, srcb=7 -> HI=2, LO=14.
REQ-043 Operand stability: change srca_e every cycle during BUSY -> div_op1 stays at the accepted value.
REQ-044 Flush mid-operation: flush_e in BUSY cycle 10 -> one-cycle div_annul, no hilo_we, state IDLE next cycle.
REQ-045 Flush versus ready: flush_e and div_ready asserted in the same cycle -> annul wins, no hilo_we.
REQ-046 Timeout and reset: divider never asserts ready -> div_annul plus div_timeout at BUSY cycle 40; rst mid-BUSY -> all outputs 0 the next cycle; back-to-back DIVs -> the second accepted the cycle after DONE.
